// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling at a fixed
// clocks-per-bit ratio, one-entry valid/ready holding register.
module uart_rx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_serial,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_frame_err,
  output logic       rx_overrun
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'((CLKS_PER_BIT / 2) - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  logic          sync1_r;
  logic          sync2_r;
  logic          prev_r;
  logic [1:0]    state_r;
  logic [CW-1:0] cnt_r;
  logic [2:0]    idx_r;
  logic [7:0]    shift_r;

  logic fall_s;
  logic half_done_s;
  logic bit_done_s;
  logic load_s;
  logic ovr_s;
  logic ferr_s;

  // Line synchronizer and edge history; all idle-high after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
      prev_r  <= 1'b1;
    end else begin
      sync1_r <= rx_serial;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
    end
  end

  // Sample strobes and stop-bit outcome decode.
  always_comb begin
    fall_s      = !sync2_r && prev_r;
    half_done_s = (cnt_r == HALF_LAST);
    bit_done_s  = (cnt_r == BIT_LAST);
    load_s      = 1'b0;
    ovr_s       = 1'b0;
    ferr_s      = 1'b0;
    if ((state_r == ST_STOP) && bit_done_s) begin
      if (sync2_r) begin
        if (!rx_valid || rx_ready) begin
          load_s = 1'b1;
        end else begin
          ovr_s = 1'b1;
        end
      end else begin
        ferr_s = 1'b1;
      end
    end else begin
      load_s = 1'b0;
    end
  end

  // Frame state machine: start-bit qualify, data shift, stop sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= '0;
      idx_r   <= 3'd0;
      shift_r <= 8'h00;
    end else begin
      case (state_r)
        ST_IDLE: begin
          cnt_r <= '0;
          idx_r <= 3'd0;
          if (fall_s) begin
            state_r <= ST_START;
          end
        end
        ST_START: begin
          if (half_done_s) begin
            cnt_r   <= '0;
            idx_r   <= 3'd0;
            // A start bit that is high again at mid-bit was a glitch.
            state_r <= sync2_r ? ST_IDLE : ST_DATA;
          end else begin
            cnt_r <= cnt_r + 1'b1;
          end
        end
        ST_DATA: begin
          if (bit_done_s) begin
            cnt_r   <= '0;
            shift_r <= {sync2_r, shift_r[7:1]};
            idx_r   <= idx_r + 3'd1;
            if (idx_r == 3'd7) begin
              state_r <= ST_STOP;
            end
          end else begin
            cnt_r <= cnt_r + 1'b1;
          end
        end
        ST_STOP: begin
          if (bit_done_s) begin
            cnt_r   <= '0;
            state_r <= ST_IDLE;
          end else begin
            cnt_r <= cnt_r + 1'b1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          cnt_r   <= '0;
          idx_r   <= 3'd0;
        end
      endcase
    end
  end

  // Holding register and one-cycle error pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data      <= 8'h00;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
      rx_overrun   <= 1'b0;
    end else begin
      rx_frame_err <= ferr_s;
      rx_overrun   <= ovr_s;
      if (load_s) begin
        rx_data  <= shift_r;
        rx_valid <= 1'b1;
      end else if (rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: one instance at 16 clocks/bit, one at 4
// clocks/bit for back-to-back frames.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ser16, ser4;
  logic       rdy16, rdy4;
  logic [7:0] data16, data4;
  logic       valid16, valid4;
  logic       ferr16, ferr4;
  logic       ovr16, ovr4;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int t0 = 0;
  int hs16 = 0, n_fe16 = 0, n_ov16 = 0;
  int hs4 = 0, n_fe4 = 0, n_ov4 = 0;
  logic [7:0] q16[$];
  logic [7:0] q4[$];

  uart_rx #(.CLKS_PER_BIT(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .rx_serial(ser16), .rx_data(data16),
    .rx_valid(valid16), .rx_ready(rdy16), .rx_frame_err(ferr16), .rx_overrun(ovr16)
  );

  uart_rx #(.CLKS_PER_BIT(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .rx_serial(ser4), .rx_data(data4),
    .rx_valid(valid4), .rx_ready(rdy4), .rx_frame_err(ferr4), .rx_overrun(ovr4)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Output monitor: pops expected bytes on every handshake, tallies pulses.
  always @(negedge clk) begin
    if (valid16 && rdy16) begin
      hs16++;
      check_eq("rx16_data", {24'd0, data16}, (q16.size() > 0) ? {24'd0, q16.pop_front()} : 32'hDEAD_BEEF);
    end
    if (valid4 && rdy4) begin
      hs4++;
      check_eq("rx4_data", {24'd0, data4}, (q4.size() > 0) ? {24'd0, q4.pop_front()} : 32'hDEAD_BEEF);
    end
    if (ferr16) n_fe16++;
    if (ovr16) n_ov16++;
    if (ferr4) n_fe4++;
    if (ovr4) n_ov4++;
    if (ferr16 || ovr16) check_eq("excl16", {31'd0, ferr16 & ovr16}, 32'd0);
    if (ferr4 || ovr4) check_eq("excl4", {31'd0, ferr4 & ovr4}, 32'd0);
  end

  // Drives one frame; abort_at >= 0 asserts reset that many cycles into it.
  task automatic send(input logic [7:0] b, input logic stop, input int cpb, input bit sel, input int abort_at);
    logic [9:0] fr;
    int n;
    fr = {stop, b, 1'b0};
    n = 0;
    for (int i = 0; i < 10; i++) begin
      for (int c = 0; c < cpb; c++) begin
        @(negedge clk);
        if (i == 0 && c == 0) t0 = cyc + 1;
        if (n == abort_at) begin
          rst_n = 1'b0;
          #1;
          check_eq("rst_valid", {31'd0, valid16}, 32'd0);
          check_eq("rst_data", {24'd0, data16}, 32'd0);
          check_eq("rst_ferr", {31'd0, ferr16}, 32'd0);
          check_eq("rst_ovr", {31'd0, ovr16}, 32'd0);
          ser16 = 1'b1;
          ser4 = 1'b1;
          repeat (3) @(negedge clk);
          rst_n = 1'b1;
          return;
        end
        if (sel) ser4 = fr[i];
        else ser16 = fr[i];
        n++;
      end
    end
  endtask

  task automatic drain(input bit sel);
    for (int i = 0; i < 400; i++) begin
      if ((sel ? q4.size() : q16.size()) == 0) break;
      @(negedge clk);
    end
    check_eq(sel ? "drain4" : "drain16", sel ? q4.size() : q16.size(), 32'd0);
  endtask

  int h, f, o;

  initial begin
    rst_n = 1'b0;
    ser16 = 1'b1;
    ser4 = 1'b1;
    rdy16 = 1'b1;
    rdy4 = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("reset_valid", {31'd0, valid16}, 32'd0);
    check_eq("reset_data", {24'd0, data16}, 32'd0);
    check_eq("reset_err", {30'd0, ferr16, ovr16}, 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Single byte with latency measurement.
    q16.push_back(8'hA5);
    fork
      send(8'hA5, 1'b1, 16, 1'b0, -1);
      begin
        for (int i = 0; i < 400; i++) begin
          @(negedge clk);
          if (valid16) break;
        end
        check_eq("t1_valid", {31'd0, valid16}, 32'd1);
        check_eq("t1_latency", cyc - t0, 32'd154);
        @(negedge clk);
        check_eq("t1_drop", {31'd0, valid16}, 32'd0);
      end
    join
    repeat (4) @(negedge clk);
    check_eq("t1_pulses", n_fe16 + n_ov16, 32'd0);

    // Back-to-back frames at 4 clocks/bit.
    h = hs4;
    q4.push_back(8'h00);
    q4.push_back(8'hFF);
    q4.push_back(8'h3C);
    send(8'h00, 1'b1, 4, 1'b1, -1);
    send(8'hFF, 1'b1, 4, 1'b1, -1);
    send(8'h3C, 1'b1, 4, 1'b1, -1);
    drain(1'b1);
    check_eq("b2b_count", hs4 - h, 32'd3);
    check_eq("b2b_ferr", n_fe4, 32'd0);

    // Framing error, then recovery.
    f = n_fe16;
    h = hs16;
    send(8'h55, 1'b0, 16, 1'b0, -1);
    @(negedge clk);
    ser16 = 1'b1;
    repeat (10) @(negedge clk);
    check_eq("fe_pulse", n_fe16 - f, 32'd1);
    check_eq("fe_nodeliver", hs16 - h, 32'd0);
    check_eq("fe_valid", {31'd0, valid16}, 32'd0);
    q16.push_back(8'h12);
    send(8'h12, 1'b1, 16, 1'b0, -1);
    drain(1'b0);

    // Glitch of H-1 cycles.
    f = n_fe16;
    o = n_ov16;
    h = hs16;
    @(negedge clk);
    ser16 = 1'b0;
    repeat (7) @(negedge clk);
    ser16 = 1'b1;
    repeat (30) @(negedge clk);
    check_eq("glitch_quiet", (n_fe16 - f) + (n_ov16 - o) + (hs16 - h), 32'd0);
    check_eq("glitch_valid", {31'd0, valid16}, 32'd0);
    q16.push_back(8'h81);
    send(8'h81, 1'b1, 16, 1'b0, -1);
    drain(1'b0);

    // Overrun with consumer stalled.
    @(posedge clk);
    #1 rdy16 = 1'b0;
    o = n_ov16;
    f = n_fe16;
    send(8'h11, 1'b1, 16, 1'b0, -1);
    send(8'h22, 1'b1, 16, 1'b0, -1);
    repeat (20) @(negedge clk);
    check_eq("ovr_pulse", n_ov16 - o, 32'd1);
    check_eq("ovr_ferr", n_fe16 - f, 32'd0);
    check_eq("ovr_valid", {31'd0, valid16}, 32'd1);
    check_eq("ovr_held", {24'd0, data16}, 32'h11);
    q16.push_back(8'h11);
    @(posedge clk);
    #1 rdy16 = 1'b1;
    drain(1'b0);
    @(negedge clk);
    check_eq("ovr_consumed", {31'd0, valid16}, 32'd0);

    // Reset mid-frame while a byte is held.
    @(posedge clk);
    #1 rdy16 = 1'b0;
    send(8'h3E, 1'b1, 16, 1'b0, -1);
    repeat (20) @(negedge clk);
    check_eq("pre_rst_valid", {31'd0, valid16}, 32'd1);
    send(8'hC3, 1'b1, 16, 1'b0, 88);
    @(posedge clk);
    #1 rdy16 = 1'b1;
    repeat (5) @(negedge clk);
    h = hs16;
    q16.push_back(8'h5A);
    send(8'h5A, 1'b1, 16, 1'b0, -1);
    drain(1'b0);
    repeat (5) @(negedge clk);
    check_eq("post_rst_count", hs16 - h, 32'd1);
    check_eq("q4_empty", q4.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial-to-parallel UART receiver, the receive end of the byte link driven by the team's UART transmitter. Recovers 8N1 frames (start bit 0, 8 data bits LSB first, stop bit 1) from an asynchronous serial line using a fixed clocks-per-bit ratio with mid-bit sampling. Delivers each byte through a one-entry valid/ready holding register and flags framing errors and overruns.

## Interface
- CLKS_PER_BIT, 16, clk cycles per serial bit; legal range 2..65535; H = CLKS_PER_BIT/2 (integer division).
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  asynchronous reset, active low; one clock; reset is asynchronous and active-low
- rx_serial  input  1  serial line, idle high, asynchronous to clk
- rx_data  output  8  received byte, stable while rx_valid=1
- rx_valid  output  1  byte held in rx_data
- rx_ready  input  1  consumer accepts rx_data when rx_valid && rx_ready
- rx_frame_err  output  1  one-cycle pulse: stop bit sampled 0
- rx_overrun  output  1  one-cycle pulse: completed byte dropped because holding register full

## Operation
- Reset (rst_n=0, immediate): state IDLE, rx_data=0, rx_valid=0, rx_frame_err=0, rx_overrun=0, synchronizer flops and edge-history flop =1, counters=0. Reset mid-frame aborts the frame; nothing delivered.
- Input path: 2-flop synchronizer; sync = second flop. prev = sync delayed one cycle.
- Bit counter cnt, width clog2(CLKS_PER_BIT); bit index idx 0..7; 8-bit shift register, right-shift, new bit into bit 7.
- IDLE: on sync==0 && prev==1 (falling edge) -> START, cnt=0. A line held low does not re-arm; a high level must be seen first.
- START: cnt increments; at cnt==H-1: sync==0 -> DATA, cnt=0, idx=0; sync==1 -> IDLE (glitch rejected, no flag).
- DATA: cnt increments; at cnt==CLKS_PER_BIT-1: shift in sync, cnt=0, idx+1; after idx==7 sample -> STOP.
- STOP: at cnt==CLKS_PER_BIT-1 sample sync, -> IDLE:
  - sync==1 and (rx_valid==0 or rx_ready==1): rx_data<=shift register, rx_valid<=1.
  - sync==1, rx_valid==1, rx_ready==0: rx_overrun pulses; held byte kept, new byte discarded.
  - sync==0: rx_frame_err pulses; byte discarded; rx_valid/rx_data unchanged.
- Handshake: rx_valid clears on the edge after rx_valid && rx_ready unless a new byte loads the same edge (then stays 1 with new data). Receiver never stalls; line sampling continues regardless of rx_ready.
- rx_frame_err and rx_overrun never assert together; each high exactly one cycle per event.

## Timing
- t0 = rising edge at which first synchronizer flop captures rx_serial=0.
- sync low after t0+1; START entered at t0+2.
- Start-bit check at edge t0+2+H; data bit k (0..7) sampled at t0+2+H+(k+1)*CLKS_PER_BIT; stop sample at t0+2+H+9*CLKS_PER_BIT.
- rx_valid / rx_frame_err / rx_overrun update on the stop-sample edge: latency 2+H+9*CLKS_PER_BIT (154 for default).
- Back in IDLE on that edge, about H-2 cycles before nominal frame end; next start bit accepted back-to-back with zero idle bits.
- rx_ready to rx_valid drop: one edge. No combinational path from any input to any output.

## Test plan
- Single byte, CLKS_PER_BIT=16: send 0xA5, rx_ready=1 -> rx_valid high at t0+154, rx_data=0xA5, no error pulses; rx_valid low one edge after handshake.
- Back-to-back frames, no idle gap, CLKS_PER_BIT=4: 0x00, 0xFF, 0x3C -> three bytes in order, correct values, no frame_err.
- Framing error: send 0x55 with stop bit 0, line then returns high -> one-cycle rx_frame_err, rx_valid stays 0; next frame 0x12 received correctly.
- Glitch rejection: low pulse of H-1 cycles on idle line -> no state beyond START, no output activity; following 0x81 received correctly.
- Overrun: rx_ready=0, send 0x11 then 0x22 -> rx_data=0x11 held, one rx_overrun pulse at second stop sample; raise rx_ready -> 0x11 consumed, rx_valid=0.
- Reset mid-frame: assert rst_n=0 during data bit 4 of 0xC3 -> outputs immediately 0/IDLE, nothing delivered; after release a full 0x5A frame received correctly.
